// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole round sequencer.
//   state_t     : round FSM states
//   LFSR_SEED   : value the hole-picking LFSR reloads on reset
//   LFSR_TAPS   : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   win_ticks() : SHOW window length in game ticks for a speed select
package game_pkg;

  typedef enum logic [2:0] {IDLE, PICK, SHOW, GAP, DONE} state_t;

  localparam int          DEF_HOLES = 10;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          WIN_W     = 4;

  // Faster speed selects give shorter windows: 8, 4, 2, 1 ticks.
  function automatic logic [WIN_W-1:0] win_ticks(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'd8;
      2'd1:    return 4'd4;
      2'd2:    return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to pick the next hole.
//   clk  : system clock
//   rst  : synchronous active-high reset, reloads LFSR_SEED
//   lfsr : current register value; steps every cycle, never zero
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer. Picks a pseudo-random hole each round, lights
// it for a speed-dependent window and judges the switch input as hit or miss.
//   clk, rst    : clock, synchronous active-high reset
//   start       : level; a registered rising edge starts/restarts a game
//   rounds      : rounds per game, latched on the accepted start
//   speed_sel   : window select, sampled in PICK
//   hit_sw      : one-hot qualified hole switches
//   pause       : only with MOLE_PAUSE_EN; freezes SHOW/GAP timing
//   hole_on     : one-hot lit hole, else 0
//   hit_pulse   : 1-cycle pulse on a hit
//   miss_pulse  : 1-cycle pulse on a window timeout
//   round_cnt   : rounds completed in the current game
//   busy, done  : game running / game finished
// Optional macro: MOLE_PAUSE_EN adds the pause input.
module mole_scheduler
  import game_pkg::*;
#(
  parameter int HOLES     = DEF_HOLES,
  parameter int TICK_DIV  = 50000000,
  parameter int GAP_TICKS = 2,
  parameter int RND_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RND_W-1:0] rounds,
  input  logic [1:0]       speed_sel,
  input  logic [HOLES-1:0] hit_sw,
`ifdef MOLE_PAUSE_EN
  input  logic             pause,
`endif
  output logic [HOLES-1:0] hole_on,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic [RND_W-1:0] round_cnt,
  output logic             busy,
  output logic             done
);

  localparam int TCK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (HOLES > 1) ? $clog2(HOLES) : 1;
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  state_t             state, state_n;
  logic               start_q, start_rise;
  logic [TCK_W-1:0]   tick_cnt;
  logic               tick_wrap, tick, frz;
  logic [WIN_W-1:0]   win_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [RND_W-1:0]   rounds_lat;
  logic [IDX_W-1:0]   prev_idx, raw_idx, pick_idx;
  logic               prev_vld;
  logic [15:0]        lfsr;
  logic               is_hit, win_end, gap_end, enter_timed;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

`ifdef MOLE_PAUSE_EN
  assign frz = pause && (state == SHOW || state == GAP);
`else
  assign frz = 1'b0;
`endif

  assign start_rise = start && !start_q;
  assign tick_wrap  = (tick_cnt == TCK_W'(TICK_DIV - 1));
  assign tick       = tick_wrap && !frz;

  // Never show the same hole twice in a row: bump a repeat to the next hole.
  always_comb begin
    raw_idx  = IDX_W'(lfsr % 16'(HOLES));
    pick_idx = raw_idx;
    if (prev_vld && raw_idx == prev_idx)
      pick_idx = (raw_idx == IDX_W'(HOLES - 1)) ? '0 : raw_idx + 1'b1;
  end

  // Hit is checked before the window timer so a hit on the final tick wins.
  assign is_hit  = (state == SHOW) && !frz && (hit_sw == hole_on);
  assign win_end = (state == SHOW) && tick && (win_cnt == 4'd1);
  assign gap_end = (state == GAP) && !frz && (gap_cnt == GAP_W'(GAP_TICKS)) &&
                   (hit_sw == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start_rise && rounds != '0) state_n = PICK;
      PICK:       state_n = SHOW;
      SHOW:       if (is_hit || win_end) state_n = GAP;
      GAP:        if (gap_end) state_n = (round_cnt == rounds_lat) ? DONE : PICK;
      default:    state_n = IDLE;
    endcase
  end

  // Windows and gaps always start on a fresh tick boundary.
  assign enter_timed = (state_n != state) && (state_n == SHOW || state_n == GAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q    <= 1'b0;
      tick_cnt   <= '0;
      win_cnt    <= '0;
      gap_cnt    <= '0;
      rounds_lat <= '0;
      round_cnt  <= '0;
      hole_on    <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      prev_idx   <= '0;
      prev_vld   <= 1'b0;
    end else begin
      start_q    <= start;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      if (enter_timed)  tick_cnt <= '0;
      else if (!frz)    tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;

      case (state)
        IDLE, DONE: begin
          if (state_n == PICK) begin
            rounds_lat <= rounds;
            round_cnt  <= '0;
          end
        end
        PICK: begin
          hole_on  <= HOLES'(1) << pick_idx;
          prev_idx <= pick_idx;
          prev_vld <= 1'b1;
          win_cnt  <= win_ticks(speed_sel);
        end
        SHOW: begin
          if (is_hit) begin
            hit_pulse <= 1'b1;
            hole_on   <= '0;
            gap_cnt   <= '0;
          end else if (tick) begin
            win_cnt <= win_cnt - 1'b1;
            if (win_cnt == 4'd1) begin
              miss_pulse <= 1'b1;
              hole_on    <= '0;
              gap_cnt    <= '0;
            end
          end
        end
        GAP: begin
          // A pulse is only ever high in the first GAP cycle.
          if (hit_pulse || miss_pulse) round_cnt <= round_cnt + 1'b1;
          if (tick && gap_cnt != GAP_W'(GAP_TICKS)) gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == PICK) || (state == SHOW) || (state == GAP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized self-checking bench for mole_scheduler (TICK_DIV=4, GAP_TICKS=2).
// The reference model predicts each hole from a free-running LFSR copy and
// derives pulse timing and gap length from window/gap tick counts.
module tb_mole_scheduler;

  localparam int HOLES     = 10;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 2;
  localparam int RND_W     = 6;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [RND_W-1:0] rounds;
  logic [1:0]       speed_sel;
  logic [HOLES-1:0] hit_sw, hole_on;
  logic             hit_pulse, miss_pulse, busy, done;
  logic [RND_W-1:0] round_cnt;

  always #5 clk = ~clk;

  mole_scheduler #(
    .HOLES(HOLES), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS), .RND_W(RND_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rounds(rounds), .speed_sel(speed_sel),
    .hit_sw(hit_sw), .hole_on(hole_on), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .round_cnt(round_cnt), .busy(busy), .done(done)
  );

  int n_chk = 0, n_err = 0;
  logic [15:0]      m_lfsr, lfsr_prev;
  int               m_prev, cur_hole, ev_cnt;
  bit               m_prev_vld;
  logic [HOLES-1:0] last_on, shown_prev;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int win_of(input int s);
    case (s)
      0:       return 8;
      1:       return 4;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // Advance one clock and sample at the falling edge; checks invariants and
  // predicts every newly lit hole.
  task automatic cyc();
    logic r;
    int raw, e;
    r = rst;
    @(negedge clk);
    lfsr_prev = m_lfsr;
    m_lfsr = r ? 16'hACE1 : lfsr_step(m_lfsr);
    if (r) m_prev_vld = 1'b0;
    chk("excl", int'(hit_pulse & miss_pulse), 0);
    chk("onehot", int'($countones(hole_on) <= 1), 1);
    if (hit_pulse || miss_pulse) ev_cnt++;
    if (last_on == '0 && hole_on != '0) begin
      raw = int'(lfsr_prev) % HOLES;
      e = (m_prev_vld && raw == m_prev) ? (raw + 1) % HOLES : raw;
      chk("pick", int'(hole_on), 1 << e);
      if (m_prev_vld) chk("no_repeat", int'(hole_on == shown_prev), 0);
      shown_prev = hole_on;
      m_prev     = e;
      m_prev_vld = 1'b1;
      cur_hole   = e;
    end
    last_on = hole_on;
  endtask

  // Leaves the bench sampling the first SHOW cycle when n != 0.
  task automatic start_game(input int n, input int s);
    rounds = RND_W'(n);
    speed_sel = 2'(s);
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    ev_cnt = 0;
    if (n != 0) begin
      chk("go_busy", int'(busy), 1);
      chk("go_rcnt", int'(round_cnt), 0);
      chk("go_done", int'(done), 0);
      chk("go_dark", int'(hole_on), 0);
      cyc();
      chk("show_lat", int'(hole_on != '0), 1);
      rounds = RND_W'($urandom);
    end
  endtask

  // mode: 0 hit at random cycle, 1 timeout, 2 wrong switch, 3 hit on final
  // tick, 4 hit on first SHOW cycle. Called on the first SHOW cycle.
  task automatic play_round(input int mode, input int spd, input int spd_next,
                            input bit last, input int rdone);
    int W, k, c, g, R, w, exp_g;
    bit got;
    logic [HOLES-1:0] oh, wrong;
    W = win_of(spd) * TICK_DIV;
    case (mode)
      0:       k = int'($urandom_range(W - 1, 0));
      3:       k = W - 1;
      4:       k = 0;
      default: k = -1;
    endcase
    oh = '0;
    oh[cur_hole] = 1'b1;
    w = (cur_hole + 1 + int'($urandom_range(HOLES - 2, 0))) % HOLES;
    wrong = '0;
    wrong[w] = 1'b1;
    c = 0;
    got = 1'b0;
    while (!got && c <= W + 1) begin
      if (mode == 2) hit_sw = wrong;
      else if (k >= 0 && c == k) hit_sw = oh;
      if (mode == 1) start = (c == 0);
      cyc();
      c++;
      got = hit_pulse | miss_pulse;
    end
    start = 1'b0;
    chk("pulse_at", c, (k >= 0) ? k + 1 : W);
    chk("hit_pulse", int'(hit_pulse), int'(k >= 0));
    chk("miss_pulse", int'(miss_pulse), int'(k < 0));
    chk("hole_clr", int'(hole_on), 0);
    chk("rcnt_pre", int'(round_cnt), rdone);
    speed_sel = 2'(spd_next);
    R = (mode == 0 || mode == 2 || mode == 3) ? int'($urandom_range(14, 0)) : 0;
    g = 0;
    while (g < 40) begin
      if (g >= R) hit_sw = '0;
      cyc();
      g++;
      if (g == 1) chk("rcnt_post", int'(round_cnt), rdone + 1);
      if (done || hole_on != '0) break;
    end
    exp_g = ((R > GAP_TICKS * TICK_DIV) ? R : GAP_TICKS * TICK_DIV) + (last ? 1 : 2);
    chk("gap_len", g, exp_g);
    chk("done", int'(done), int'(last));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sp[6];
    rst = 1'b1; start = 1'b0; rounds = '0; speed_sel = '0; hit_sw = '0;
    last_on = '0; shown_prev = '0; m_prev_vld = 1'b0; ev_cnt = 0;
    m_prev = 0; cur_hole = 0;
    cyc();
    cyc();
    chk("rst_hole", int'(hole_on), 0);
    chk("rst_hit", int'(hit_pulse), 0);
    chk("rst_miss", int'(miss_pulse), 0);
    chk("rst_rcnt", int'(round_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    // Hit on the first SHOW cycle.
    start_game(1, 0);
    play_round(4, 0, 0, 1'b1, 0);
    chk("ev_t1", ev_cnt, 1);
    chk("rcnt_t1", int'(round_cnt), 1);

    // Timeout, then hit coinciding with the final tick.
    start_game(1, 3);
    play_round(1, 3, 0, 1'b1, 0);
    start_game(1, 2);
    play_round(3, 2, 0, 1'b1, 0);

    // Wrong switch for a whole window, then a switch held into the gap.
    start_game(2, 1);
    play_round(2, 1, 0, 1'b0, 0);
    play_round(0, 0, 0, 1'b1, 1);

    // Full random game, then restart from DONE.
    for (int i = 0; i < 6; i++) sp[i] = int'($urandom_range(3, 0));
    start_game(5, sp[0]);
    for (int i = 0; i < 5; i++)
      play_round(int'($urandom_range(3, 0)), sp[i], sp[i + 1], i == 4, i);
    chk("ev_t5", ev_cnt, 5);
    chk("rcnt_t5", int'(round_cnt), 5);
    start_game(3, sp[5]);
    for (int i = 0; i < 3; i++)
      play_round(int'($urandom_range(3, 0)), (i == 0) ? sp[5] : 1, 1, i == 2, i);
    chk("ev_rs", ev_cnt, 3);

    // Mid-SHOW reset, then a zero-round start.
    start_game(4, 0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_hole", int'(hole_on), 0);
    chk("mrst_pulse", int'(hit_pulse | miss_pulse), 0);
    chk("mrst_rcnt", int'(round_cnt), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    start_game(0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("zero_busy", int'(busy), 0);
      chk("zero_done", int'(done), 0);
      chk("zero_hole", int'(hole_on), 0);
    end
    start_game(1, 3);
    play_round(1, 3, 0, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
